// File: rtl/raster_pixel_writeback_if.sv
// Avalon-MM master bus between the pixel write-back stage and the SDRAM controller.
interface raster_pixel_writeback_if;
    logic [25:0] master_address;
    logic        master_read;
    logic        master_write;
    logic [3:0]  master_byteenable;
    logic [31:0] master_writedata;
    logic [31:0] master_readdata;
    logic        master_readdatavalid;
    logic        master_waitrequest;

    modport master (
        output master_address, master_read, master_write, master_byteenable, master_writedata,
        input  master_readdata, master_readdatavalid, master_waitrequest
    );

    modport slave (
        input  master_address, master_read, master_write, master_byteenable, master_writedata,
        output master_readdata, master_readdatavalid, master_waitrequest
    );
endinterface

// File: rtl/raster_pixel_writeback.sv
// Rasterizer back-end: per-lane pixel FIFOs, round-robin merge, optional z-test, depth/colour write-back.
// Optional feature macro: RASTER_WB_DEPTH_TEST_EN (depth read, compare and depth write).
module raster_pixel_writeback #(
    parameter int NCH        = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int OFFW       = 19
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [25:0]         frame_buffer_base,
    input  logic [25:0]         depth_buffer_base,
    input  logic [NCH-1:0]      pix_valid,
    output logic [NCH-1:0]      pix_ready,
    input  logic [NCH*OFFW-1:0] pix_offset,
    input  logic [NCH*24-1:0]   pix_color,
    input  logic [NCH*32-1:0]   pix_depth,
    raster_pixel_writeback_if.master bus,
    output logic                busy,
    output logic [31:0]         pix_written,
    output logic [31:0]         pix_rejected
);
    localparam int PW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PTRW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_DEPTH, WR_COLOR} state_t;

    state_t         state_q;
    logic [PW-1:0]  rr_q, rr_d, grant_idx, cand;
    logic           grant_valid;
    logic [NCH-1:0] empty, full, push, pop;

    logic [PTRW-1:0] wr_ptr_q [NCH];
    logic [PTRW-1:0] rd_ptr_q [NCH];
    logic [CNTW-1:0] count_q  [NCH];
    logic [OFFW-1:0] off_mem  [NCH][FIFO_DEPTH];
    logic [23:0]     col_mem  [NCH][FIFO_DEPTH];

    logic [25:0] address_q;
    logic [31:0] wdata_q;
    logic        write_q;
    logic [31:0] written_q;
    logic [OFFW-1:0] g_off;
    logic [23:0]     g_color;

    function automatic logic [25:0] word_addr(input logic [25:0] base, input logic [OFFW-1:0] off);
        logic [OFFW+1:0] byte_off;
        byte_off = {off, 2'b00};
        return base + 26'(byte_off);
    endfunction

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(FIFO_DEPTH - 1)) ? '0 : p + PTRW'(1);
    endfunction

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            empty[i] = (count_q[i] == '0);
            full[i]  = (count_q[i] == CNTW'(FIFO_DEPTH));
        end
    end

    assign pix_ready = ~full;
    assign push      = pix_valid & ~full;

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (push[i]) wr_ptr_q[i] <= ptr_inc(wr_ptr_q[i]);
                if (pop[i])  rd_ptr_q[i] <= ptr_inc(rd_ptr_q[i]);
                case ({push[i], pop[i]})
                    2'b10:   count_q[i] <= count_q[i] + CNTW'(1);
                    2'b01:   count_q[i] <= count_q[i] - CNTW'(1);
                    default: count_q[i] <= count_q[i];
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NCH; i++) begin
            if (push[i]) begin
                off_mem[i][wr_ptr_q[i]] <= pix_offset[i*OFFW +: OFFW];
                col_mem[i][wr_ptr_q[i]] <= pix_color[i*24 +: 24];
            end
        end
    end

    // Scan lanes starting at the round-robin pointer; the first non-empty one wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = rr_q;
        for (int i = 0; i < NCH; i++) begin
            if (!grant_valid && !empty[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
            cand = (cand == PW'(NCH - 1)) ? '0 : cand + PW'(1);
        end
    end

    always_comb begin
        pop = '0;
        if (state_q == IDLE && grant_valid) pop[grant_idx] = 1'b1;
    end

    assign rr_d    = (grant_idx == PW'(NCH - 1)) ? '0 : grant_idx + PW'(1);
    assign g_off   = off_mem[grant_idx][rd_ptr_q[grant_idx]];
    assign g_color = col_mem[grant_idx][rd_ptr_q[grant_idx]];
    assign busy    = (~&empty) || (state_q != IDLE);

    assign bus.master_address    = address_q;
    assign bus.master_write      = write_q;
    assign bus.master_byteenable = 4'b1111;
    assign bus.master_writedata  = wdata_q;
    assign pix_written           = written_q;

`ifdef RASTER_WB_DEPTH_TEST_EN
    logic [31:0]     depth_mem [NCH][FIFO_DEPTH];
    logic [OFFW-1:0] off_q;
    logic [23:0]     color_q;
    logic [31:0]     depth_q;
    logic            read_q;
    logic [31:0]     rejected_q;

    always_ff @(posedge clock) begin
        for (int i = 0; i < NCH; i++) begin
            if (push[i]) depth_mem[i][wr_ptr_q[i]] <= pix_depth[i*32 +: 32];
        end
    end

    assign bus.master_read = read_q;
    assign pix_rejected    = rejected_q;

    // Outputs are registered alongside the state so the bus stays stable while stalled.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            rr_q       <= '0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            address_q  <= '0;
            wdata_q    <= '0;
            written_q  <= '0;
            rejected_q <= '0;
            off_q      <= '0;
            color_q    <= '0;
            depth_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        rr_q      <= rr_d;
                        off_q     <= g_off;
                        color_q   <= g_color;
                        depth_q   <= depth_mem[grant_idx][rd_ptr_q[grant_idx]];
                        address_q <= word_addr(depth_buffer_base, g_off);
                        read_q    <= 1'b1;
                        state_q   <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (!bus.master_waitrequest) begin
                        read_q  <= 1'b0;
                        state_q <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    // Ties count as occluded: only strictly nearer pixels are written.
                    if (bus.master_readdatavalid) begin
                        if (depth_q < bus.master_readdata) begin
                            write_q <= 1'b1;
                            wdata_q <= depth_q;
                            state_q <= WR_DEPTH;
                        end else begin
                            rejected_q <= rejected_q + 32'd1;
                            state_q    <= IDLE;
                        end
                    end
                end
                WR_DEPTH: begin
                    if (!bus.master_waitrequest) begin
                        address_q <= word_addr(frame_buffer_base, off_q);
                        wdata_q   <= {8'h00, color_q};
                        state_q   <= WR_COLOR;
                    end
                end
                WR_COLOR: begin
                    if (!bus.master_waitrequest) begin
                        write_q   <= 1'b0;
                        written_q <= written_q + 32'd1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
`else
    logic unused_ok;
    assign unused_ok = ^{depth_buffer_base, pix_depth, bus.master_readdata, bus.master_readdatavalid};

    assign bus.master_read = 1'b0;
    assign pix_rejected    = 32'd0;

    // Without the z-test every granted pixel goes straight to its colour write.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            write_q   <= 1'b0;
            address_q <= '0;
            wdata_q   <= '0;
            written_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        rr_q      <= rr_d;
                        address_q <= word_addr(frame_buffer_base, g_off);
                        wdata_q   <= {8'h00, g_color};
                        write_q   <= 1'b1;
                        state_q   <= WR_COLOR;
                    end
                end
                WR_COLOR: begin
                    if (!bus.master_waitrequest) begin
                        write_q   <= 1'b0;
                        written_q <= written_q + 32'd1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
`endif
endmodule

// File: tb/tb_raster_pixel_writeback.sv
// Scoreboard bench for raster_pixel_writeback: expected bus transactions are queued as pixels are driven.
module tb_raster_pixel_writeback;
    localparam int NCH        = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int OFFW       = 19;
    localparam logic [25:0] FRAME_BASE = 26'h100000;
    localparam logic [25:0] DEPTH_BASE = 26'h200000;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic [NCH-1:0]      pix_valid = '0;
    logic [NCH-1:0]      pix_ready;
    logic [NCH*OFFW-1:0] pix_offset = '0;
    logic [NCH*24-1:0]   pix_color = '0;
    logic [NCH*32-1:0]   pix_depth = '0;
    logic                busy;
    logic [31:0]         pix_written, pix_rejected;

    raster_pixel_writeback_if avm();

    raster_pixel_writeback #(.NCH(NCH), .FIFO_DEPTH(FIFO_DEPTH), .OFFW(OFFW)) dut (
        .clock(clock), .reset(reset),
        .frame_buffer_base(FRAME_BASE), .depth_buffer_base(DEPTH_BASE),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_offset(pix_offset), .pix_color(pix_color), .pix_depth(pix_depth),
        .bus(avm),
        .busy(busy), .pix_written(pix_written), .pix_rejected(pix_rejected)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          isWrite;
        logic [25:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t        sbQueue[$];
    logic [31:0] depthMem [logic [25:0]];
    int          checksDone = 0, checksPassed = 0;
    int          cycleCount = 0, pushCycle = 0, lastWriteCycle = 0;
    int          rdLatency = 2;
    logic [31:0] expWritten = 0, expRejected = 0;
    logic [31:0] slaveData;
    bit          stallPending = 0;
    logic [25:0] prevAddr;
    logic [31:0] prevData;
    logic        prevRd, prevWr;

    always @(posedge clock) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checksDone++;
        if (actual === expected) checksPassed++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    endtask

    function automatic logic [31:0] memRead(input logic [25:0] a);
        if (depthMem.exists(a)) return depthMem[a];
        return 32'hFFFF_FFFF;
    endfunction

    // Expected transactions for one pixel, derived from bases, offset and the bench's depth table.
    task automatic expectPixel(input logic [OFFW-1:0] off, input logic [23:0] color, input logic [31:0] depth);
        logic [OFFW+1:0] byteOff;
        logic [25:0]     colAddr, depAddr;
        byteOff = {off, 2'b00};
        colAddr = FRAME_BASE + 26'(byteOff);
        depAddr = DEPTH_BASE + 26'(byteOff);
`ifdef RASTER_WB_DEPTH_TEST_EN
        sbQueue.push_back('{1'b0, depAddr, 32'h0});
        if (depth < memRead(depAddr)) begin
            sbQueue.push_back('{1'b1, depAddr, depth});
            sbQueue.push_back('{1'b1, colAddr, {8'h00, color}});
            expWritten++;
        end else begin
            expRejected++;
        end
`else
        sbQueue.push_back('{1'b1, colAddr, {8'h00, color}});
        expWritten++;
`endif
    endtask

    task automatic setLane(input int lane, input logic [OFFW-1:0] off, input logic [23:0] color, input logic [31:0] depth);
        pix_offset[lane*OFFW +: OFFW] = off;
        pix_color[lane*24 +: 24]      = color;
        pix_depth[lane*32 +: 32]      = depth;
        pix_valid[lane]               = 1'b1;
    endtask

    // Called and returns #1 after a rising edge; holds valid until the lane accepts.
    task automatic applyStimulus(input int lane, input logic [OFFW-1:0] off, input logic [23:0] color, input logic [31:0] depth);
        bit accepted = 0;
        setLane(lane, off, color, depth);
        expectPixel(off, color, depth);
        for (int n = 0; n < 200 && !accepted; n++) begin
            @(negedge clock);
            if (pix_ready[lane]) begin
                accepted  = 1;
                pushCycle = cycleCount + 1;
            end
            @(posedge clock);
            #1;
        end
        pix_valid[lane] = 1'b0;
        checkOutput("push_accept", accepted, 1);
    endtask

    task automatic applyReset();
        reset     = 1'b0;
        pix_valid = '0;
        sbQueue.delete();
        expWritten  = 0;
        expRejected = 0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic waitDrain(input string tag);
        int n = 0;
        while ((busy || sbQueue.size() != 0) && n < 300) begin
            @(posedge clock);
            #1;
            n++;
        end
        checkOutput(tag, n < 300, 1);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_read"}, avm.master_read, 0);
        checkOutput({tag, "_write"}, avm.master_write, 0);
        checkOutput({tag, "_addr"}, avm.master_address, 0);
        checkOutput({tag, "_wdata"}, avm.master_writedata, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_ready"}, pix_ready, {NCH{1'b1}});
        checkOutput({tag, "_written"}, pix_written, 0);
        checkOutput({tag, "_rejected"}, pix_rejected, 0);
    endtask

    // Bus monitor: stall stability plus in-order scoreboard compare of every accepted request.
    always @(negedge clock) begin
        if (!reset) begin
            stallPending = 0;
        end else begin
            if (stallPending) begin
                checkOutput("stall_addr", avm.master_address, prevAddr);
                checkOutput("stall_data", avm.master_writedata, prevData);
                checkOutput("stall_rd", avm.master_read, prevRd);
                checkOutput("stall_wr", avm.master_write, prevWr);
            end
            if ((avm.master_read || avm.master_write) && !avm.master_waitrequest) begin
                txn_t e;
                checkOutput("rd_wr_excl", avm.master_read && avm.master_write, 0);
                checkOutput("sb_nonempty", sbQueue.size() != 0, 1);
                checkOutput("byteenable", avm.master_byteenable, 4'hF);
                if (sbQueue.size() != 0) begin
                    e = sbQueue.pop_front();
                    checkOutput("req_kind", avm.master_write, e.isWrite);
                    checkOutput("req_addr", avm.master_address, e.addr);
                    if (e.isWrite) checkOutput("req_data", avm.master_writedata, e.data);
                end
                if (avm.master_write) lastWriteCycle = cycleCount + 1;
                stallPending = 0;
            end else if (avm.master_read || avm.master_write) begin
                stallPending = 1;
                prevAddr = avm.master_address;
                prevData = avm.master_writedata;
                prevRd   = avm.master_read;
                prevWr   = avm.master_write;
            end else begin
                stallPending = 0;
            end
        end
    end

    // Avalon slave: returns the depth table entry rdLatency cycles after a read is accepted.
    always begin
        @(negedge clock);
        if (reset && avm.master_read && !avm.master_waitrequest) begin
            slaveData = memRead(avm.master_address);
            repeat (rdLatency) @(posedge clock);
            #1;
            avm.master_readdata      = slaveData;
            avm.master_readdatavalid = 1'b1;
            @(posedge clock);
            #1;
            avm.master_readdatavalid = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        avm.master_readdata      = '0;
        avm.master_readdatavalid = 1'b0;
        avm.master_waitrequest   = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        checkResetState("rst");
        @(posedge clock);
        #1;

        $display("[TB] scenario 1: single nearer pixel");
        rdLatency = 2;
        depthMem[26'h200014] = 32'd20;
        applyStimulus(0, 19'd5, 24'hABCDEF, 32'd10);
        waitDrain("s1_drain");
        checkOutput("s1_written", pix_written, expWritten);
        checkOutput("s1_rejected", pix_rejected, expRejected);
`ifdef RASTER_WB_DEPTH_TEST_EN
        checkOutput("s1_latency", lastWriteCycle - pushCycle, 4 + rdLatency);
`else
        checkOutput("s1_latency", lastWriteCycle - pushCycle, 2);
`endif

        $display("[TB] scenario 2: depth tie");
        depthMem[26'h200014] = 32'd10;
        applyStimulus(0, 19'd5, 24'h123456, 32'd10);
        waitDrain("s2_drain");
        checkOutput("s2_written", pix_written, expWritten);
        checkOutput("s2_rejected", pix_rejected, expRejected);
        checkOutput("s2_busy", busy, 0);

        $display("[TB] scenario 3: two lanes, three pixels each");
        applyReset();
        for (int p = 0; p < 3; p++) begin
            setLane(0, 19'(10 + p), 24'h0A0000 + 24'(p), 32'd100 + 32'(p));
            setLane(1, 19'(20 + p), 24'h0B0000 + 24'(p), 32'd200 + 32'(p));
            expectPixel(19'(10 + p), 24'h0A0000 + 24'(p), 32'd100 + 32'(p));
            expectPixel(19'(20 + p), 24'h0B0000 + 24'(p), 32'd200 + 32'(p));
            @(negedge clock);
            checkOutput("s3_ready", pix_ready, {NCH{1'b1}});
            @(posedge clock);
            #1;
        end
        pix_valid = '0;
        n = 0;
        while (pix_written != 32'd5 && n < 300) begin @(posedge clock); #1; n++; end
        checkOutput("s3_reach5", pix_written, 5);
        checkOutput("s3_busy_before6", busy, 1);
        n = 0;
        while (pix_written != 32'd6 && n < 300) begin @(posedge clock); #1; n++; end
        checkOutput("s3_reach6", pix_written, 6);
        checkOutput("s3_busy_after6", busy, 0);
        waitDrain("s3_drain");

        $display("[TB] scenario 4: lane0 back-pressure");
        avm.master_waitrequest = 1'b1;
        for (int p = 0; p < FIFO_DEPTH + 1; p++)
            applyStimulus(0, 19'(30 + p), 24'h0C0000 + 24'(p), 32'd300 + 32'(p));
        @(negedge clock);
        checkOutput("s4_ready0", pix_ready[0], 0);
        checkOutput("s4_ready1", pix_ready[1], 1);
        @(posedge clock);
        #1;
        avm.master_waitrequest = 1'b0;
        waitDrain("s4_drain");
        checkOutput("s4_written", pix_written, expWritten);

        $display("[TB] scenario 5: long stall on first write");
`ifdef RASTER_WB_DEPTH_TEST_EN
        applyStimulus(1, 19'd40, 24'h0D0D0D, 32'd7);
        n = 0;
        while (!(avm.master_read && !avm.master_waitrequest) && n < 100) begin @(negedge clock); n++; end
        checkOutput("s5_read_seen", n < 100, 1);
        @(posedge clock);
        #1;
        avm.master_waitrequest = 1'b1;
`else
        avm.master_waitrequest = 1'b1;
        applyStimulus(1, 19'd40, 24'h0D0D0D, 32'd7);
`endif
        n = 0;
        while (!avm.master_write && n < 100) begin @(negedge clock); n++; end
        checkOutput("s5_write_seen", n < 100, 1);
        repeat (7) @(posedge clock);
        #1;
        avm.master_waitrequest = 1'b0;
        waitDrain("s5_drain");
        checkOutput("s5_written", pix_written, expWritten);

        $display("[TB] scenario 6: reset mid-transaction");
`ifdef RASTER_WB_DEPTH_TEST_EN
        rdLatency = 4;
        applyStimulus(0, 19'd50, 24'h0E0E0E, 32'd9);
        n = 0;
        while (!(avm.master_read && !avm.master_waitrequest) && n < 100) begin @(negedge clock); n++; end
        checkOutput("s6_read_seen", n < 100, 1);
        @(posedge clock);
        #1;
        applyReset();
`else
        avm.master_waitrequest = 1'b1;
        applyStimulus(0, 19'd50, 24'h0E0E0E, 32'd9);
        n = 0;
        while (!avm.master_write && n < 100) begin @(negedge clock); n++; end
        checkOutput("s6_write_seen", n < 100, 1);
        @(posedge clock);
        #1;
        applyReset();
        avm.master_waitrequest = 1'b0;
`endif
        @(negedge clock);
        checkResetState("s6");
        repeat (8) @(posedge clock);
        #1;
        checkResetState("s6_late");

        $display("%0d/%0d checks passed", checksPassed, checksDone);
        $finish;
    end
endmodule
